// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and the slot positions of quotient/remainder in dout.
package seq_divider_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;

    // dout_data is {quotient, remainder}: slot index times WIDTH gives the LSB
    localparam int unsigned QUO_SLOT = 1;
    localparam int unsigned REM_SLOT = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, emit one quotient bit.
module seq_divider_div_step
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // rem_i < divisor keeps rem_sh - divisor inside (-2^W, 2^W), so bit W is the borrow
    always_comb begin
        rem_sh  = {rem_i, q_msb_i};
        diff    = rem_sh - {1'b0, divisor_i};
        q_bit_o = ~diff[WIDTH];
        rem_o   = q_bit_o ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with independent operand handshakes.
// Optional macro DIV_EARLY_OUT_EN: skip CALC for divide-by-zero or |dividend| < |divisor|.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH  = DIV_WIDTH_DEFAULT,
    parameter bit          SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [WIDTH-1:0]     dividend_data,
    input  logic                 dividend_valid,
    output logic                 dividend_ready,
    input  logic [WIDTH-1:0]     divisor_data,
    input  logic                 divisor_valid,
    output logic                 divisor_ready,
    output logic                 dout_valid,
    output logic [2*WIDTH-1:0]   dout_data
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_e          state_q;
    logic                dividend_ready_q, divisor_ready_q, dout_valid_q;
    logic [2*WIDTH-1:0]  dout_data_q;
    logic                have_dvd_q, have_dvs_q;
    logic [WIDTH-1:0]    dvd_q, dvs_q, dvs_abs_q, acc_q, rem_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                dvd_fire, dvs_fire, start, neg_q, neg_r, div0;
    logic [WIDTH-1:0]    eff_dvd, eff_dvs, abs_dvd, abs_dvs;
    logic [WIDTH-1:0]    step_rem, q_raw, res_quo, res_rem;
    logic                step_bit;
`ifdef DIV_EARLY_OUT_EN
    logic                early;
`endif

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return (SIGNED && x[WIDTH-1]) ? -x : x;
    endfunction

    seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .q_msb_i   (acc_q[WIDTH-1]),
        .divisor_i (dvs_abs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_bit)
    );

    always_comb begin
        dvd_fire = dividend_ready_q & dividend_valid;
        dvs_fire = divisor_ready_q & divisor_valid;
        eff_dvd  = dvd_fire ? dividend_data : dvd_q;
        eff_dvs  = dvs_fire ? divisor_data  : dvs_q;
        start    = (dvd_fire | have_dvd_q) & (dvs_fire | have_dvs_q) & (dvd_fire | dvs_fire);
        abs_dvd  = abs_val(eff_dvd);
        abs_dvs  = abs_val(eff_dvs);
`ifdef DIV_EARLY_OUT_EN
        early    = (eff_dvs == '0) || (abs_dvd < abs_dvs);
`endif
        // Final result is taken from the last step directly so DONE follows CALC with no gap
        q_raw    = {acc_q[WIDTH-2:0], step_bit};
        neg_q    = SIGNED & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
        neg_r    = SIGNED & dvd_q[WIDTH-1];
        div0     = (dvs_q == '0);
        res_quo  = div0 ? '1    : (neg_q ? -q_raw    : q_raw);
        res_rem  = div0 ? dvd_q : (neg_r ? -step_rem : step_rem);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= ST_IDLE;
            dividend_ready_q <= 1'b0;
            divisor_ready_q  <= 1'b0;
            dout_valid_q     <= 1'b0;
            dout_data_q      <= '0;
            have_dvd_q       <= 1'b0;
            have_dvs_q       <= 1'b0;
            dvd_q            <= '0;
            dvs_q            <= '0;
            dvs_abs_q        <= '0;
            acc_q            <= '0;
            rem_q            <= '0;
            cnt_q            <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dvd_fire) begin
                        dvd_q            <= dividend_data;
                        have_dvd_q       <= 1'b1;
                        dividend_ready_q <= 1'b0;
                    end else if (!have_dvd_q) begin
                        dividend_ready_q <= 1'b1;
                    end
                    if (dvs_fire) begin
                        dvs_q           <= divisor_data;
                        have_dvs_q      <= 1'b1;
                        divisor_ready_q <= 1'b0;
                    end else if (!have_dvs_q) begin
                        divisor_ready_q <= 1'b1;
                    end
                    if (start) begin
                        acc_q     <= abs_dvd;
                        dvs_abs_q <= abs_dvs;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        state_q   <= ST_CALC;
`ifdef DIV_EARLY_OUT_EN
                        if (early) begin
                            state_q      <= ST_DONE;
                            dout_valid_q <= 1'b1;
                            dout_data_q[QUO_SLOT*WIDTH +: WIDTH] <= (eff_dvs == '0) ? '1 : '0;
                            dout_data_q[REM_SLOT*WIDTH +: WIDTH] <= eff_dvd;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    rem_q <= step_rem;
                    acc_q <= q_raw;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_q      <= ST_DONE;
                        dout_valid_q <= 1'b1;
                        dout_data_q[QUO_SLOT*WIDTH +: WIDTH] <= res_quo;
                        dout_data_q[REM_SLOT*WIDTH +: WIDTH] <= res_rem;
                    end
                end
                ST_DONE: begin
                    state_q          <= ST_IDLE;
                    dout_valid_q     <= 1'b0;
                    dividend_ready_q <= 1'b1;
                    divisor_ready_q  <= 1'b1;
                    have_dvd_q       <= 1'b0;
                    have_dvs_q       <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dividend_ready = dividend_ready_q;
    assign divisor_ready  = divisor_ready_q;
    assign dout_valid     = dout_valid_q;
    assign dout_data      = dout_data_q;

endmodule
